// File: rtl/uart_rx_buffer.sv
// Receive-side buffer behind the UART receive controller. It drains the controller's
// single-byte holding register, tags each byte with its frame error, and queues it
// in a circular FIFO for the host. Sticky flags record dropped bytes and overruns.
module uart_rx_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Resetn,
  // receive controller side
  input  logic             rx_empty,
  input  logic [7:0]       rx_data,
  input  logic             rx_frame_error,
  input  logic             rx_overrun,
  output logic             rx_unload,
  // host side
  output logic [7:0]       m_data,
  output logic             m_frame_error,
  output logic             m_valid,
  input  logic             m_ready,
  // control and status
  input  logic             flush,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overflow,
  output logic             overrun
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StUnload,
    StWait
  } state_e;

  state_e             state_q, state_d;
  logic               rx_unload_q, rx_unload_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               overflow_q, overflow_d;
  logic               overrun_q, overrun_d;
  logic [8:0]         mem_q [DEPTH];

  logic push_req;
  logic push_ok;
  logic pop;
  logic drop;

  // Drain FSM next state: one unload per held byte, then wait for Empty to rise
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!rx_empty) state_d = StUnload;
      StUnload: state_d = StWait;
      StWait:   if (rx_empty) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // rx_unload is registered so the controller sees a clean single-cycle pulse
  assign rx_unload_d = (state_d == StUnload);

  // Push/pop qualification; a pop frees a slot for a same-cycle push at full
  always_comb begin
    push_req = (state_q == StUnload);
    pop      = m_valid && m_ready;
    push_ok  = push_req && !flush && (!full_q || pop);
    // A push discarded by flush is intentional and not an overflow
    drop     = push_req && !flush && full_q && !pop;
  end

  // Pointer, occupancy and sticky flag next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
    full_d     = (count_d == CNT_W'(DEPTH));
    // Set events win over err_clr
    overflow_d = drop | (overflow_q & ~err_clr);
    overrun_d  = rx_overrun | (overrun_q & ~err_clr);
  end

  // Control state with asynchronous reset
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= StIdle;
      rx_unload_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_unload_q <= rx_unload_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      overrun_q   <= overrun_d;
    end
  end

  // FIFO storage, {frame_error, data}; contents need no reset
  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {rx_frame_error, rx_data};
  end

  // First-word-fall-through head from the registered read pointer
  always_comb begin
    m_data        = mem_q[rd_ptr_q][7:0];
    m_frame_error = mem_q[rd_ptr_q][8];
    m_valid       = (count_q != '0);
  end

  assign rx_unload = rx_unload_q;
  assign count     = count_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: a hand-written vector table, directed corner sequences
// and a randomized phase, all checked every cycle against a queue-based model.
module tb_uart_rx_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             Clk = 1'b0;
  logic             Resetn;
  logic             rx_empty;
  logic [7:0]       rx_data;
  logic             rx_frame_error;
  logic             rx_overrun;
  logic             rx_unload;
  logic [7:0]       m_data;
  logic             m_frame_error;
  logic             m_valid;
  logic             m_ready;
  logic             flush;
  logic             err_clr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             overflow;
  logic             overrun;

  uart_rx_buffer #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .Clk           (Clk),
    .Resetn        (Resetn),
    .rx_empty      (rx_empty),
    .rx_data       (rx_data),
    .rx_frame_error(rx_frame_error),
    .rx_overrun    (rx_overrun),
    .rx_unload     (rx_unload),
    .m_data        (m_data),
    .m_frame_error (m_frame_error),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .flush         (flush),
    .err_clr       (err_clr),
    .count         (count),
    .full          (full),
    .overflow      (overflow),
    .overrun       (overrun)
  );

  always #5 Clk = ~Clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: FIFO contents as a queue, sticky flags, and the unload rule
  // "one unload the cycle after Empty is seen low, then none until Empty is seen high".
  logic [8:0] q[$];
  bit         mdl_ovf;
  bit         mdl_ovr;
  bit         armed;
  bit         exp_unl;
  bit         saw_unl;
  logic [7:0] popped[$];
  int         max_cnt;

  typedef struct {
    logic       empty;
    logic [7:0] data;
    logic       fe;
    logic       rdy;
    logic       ovr_in;
    logic       clr;
    logic       e_unl;
    logic       e_valid;
    int         e_cnt;
    logic       e_ovr;
    logic       chk_d;
    logic [7:0] e_data;
    logic       e_fe;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic e, logic [7:0] d, logic f, logic r, logic o, logic c,
                              logic eu, logic ev, int ec, logic eo, logic cd,
                              logic [7:0] ed, logic ef);
    vec_t v;
    v.empty = e;  v.data = d;  v.fe = f;  v.rdy = r;  v.ovr_in = o;  v.clr = c;
    v.e_unl = eu; v.e_valid = ev; v.e_cnt = ec; v.e_ovr = eo;
    v.chk_d = cd; v.e_data = ed; v.e_fe = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mdl_ovf = 0;
    mdl_ovr = 0;
    armed   = 1;
    exp_unl = 0;
  endtask

  // Called at posedge+1 with inputs applied; compares at mid-cycle.
  task automatic sample();
    #4;
    saw_unl = rx_unload;
    chk("rx_unload", rx_unload, exp_unl);
    chk("m_valid", m_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("overflow", overflow, mdl_ovf);
    chk("overrun", overrun, mdl_ovr);
    if (q.size() != 0) begin
      chk("m_data", m_data, q[0][7:0]);
      chk("m_frame_error", m_frame_error, q[0][8]);
    end
    if (m_valid && m_ready) popped.push_back(m_data);
    if (int'(count) > max_cnt) max_cnt = int'(count);
  endtask

  // Apply the current inputs to the model, then move to posedge+1.
  task automatic advance();
    int sz;
    bit pop;
    bit set_ovf;
    sz      = q.size();
    pop     = (sz != 0) && m_ready;
    set_ovf = 0;
    if (flush) begin
      q.delete();
    end else begin
      if (exp_unl) begin
        if (sz < DEPTH || pop) q.push_back({rx_frame_error, rx_data});
        else set_ovf = 1;
      end
      if (pop) void'(q.pop_front());
    end
    mdl_ovf = set_ovf || (mdl_ovf && !err_clr);
    mdl_ovr = rx_overrun || (mdl_ovr && !err_clr);
    if (exp_unl) begin
      armed   = 0;
      exp_unl = 0;
    end else if (armed) begin
      if (!rx_empty) exp_unl = 1;
    end else if (rx_empty) begin
      armed = 1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  // Act as the receive controller for one byte; optionally pop in the unload cycle.
  task automatic offer(input logic [7:0] d, input logic fe, input bit rdy_on_unl);
    bit done;
    done           = 0;
    rx_empty       = 1'b0;
    rx_data        = d;
    rx_frame_error = fe;
    for (int k = 0; k < 8 && !done; k++) begin
      if (rdy_on_unl) m_ready = exp_unl;
      sample();
      if (saw_unl) done = 1;
      advance();
    end
    if (rdy_on_unl) m_ready = 1'b0;
    chk("unload_seen", done, 1);
    rx_empty = 1'b1;
    tick();
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int k = 0; k < DEPTH + 4; k++) tick();
    m_ready = 1'b0;
  endtask

  initial begin
    bit found;
    bit late;
    bit ctl_has;
    int bias;

    Resetn = 1'b0; rx_empty = 1'b1; rx_data = '0; rx_frame_error = 1'b0;
    rx_overrun = 1'b0; m_ready = 1'b0; flush = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Resetn = 1'b1;

    // Single byte, stickies and frame-error tagging, cycle by cycle from reset
    tbl[0]  = mk(1, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0,  0, 8'h00, 0);
    tbl[1]  = mk(0, 8'hA5, 0, 0, 0, 0,  0, 0, 0, 0,  0, 8'h00, 0);
    tbl[2]  = mk(0, 8'hA5, 0, 0, 0, 0,  1, 0, 0, 0,  0, 8'h00, 0);
    tbl[3]  = mk(1, 8'h00, 0, 0, 0, 0,  0, 1, 1, 0,  1, 8'hA5, 0);
    tbl[4]  = mk(1, 8'h00, 0, 1, 0, 0,  0, 1, 1, 0,  1, 8'hA5, 0);
    tbl[5]  = mk(1, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0,  0, 8'h00, 0);
    tbl[6]  = mk(1, 8'h00, 0, 0, 1, 0,  0, 0, 0, 0,  0, 8'h00, 0);
    tbl[7]  = mk(1, 8'h00, 0, 0, 0, 0,  0, 0, 0, 1,  0, 8'h00, 0);
    tbl[8]  = mk(1, 8'h00, 0, 0, 1, 1,  0, 0, 0, 1,  0, 8'h00, 0);
    tbl[9]  = mk(1, 8'h00, 0, 0, 0, 1,  0, 0, 0, 1,  0, 8'h00, 0);
    tbl[10] = mk(0, 8'h3C, 1, 0, 0, 0,  0, 0, 0, 0,  0, 8'h00, 0);
    tbl[11] = mk(0, 8'h3C, 1, 0, 0, 0,  1, 0, 0, 0,  0, 8'h00, 0);
    tbl[12] = mk(1, 8'h00, 0, 0, 0, 0,  0, 1, 1, 0,  1, 8'h3C, 1);
    tbl[13] = mk(0, 8'h11, 0, 0, 0, 0,  0, 1, 1, 0,  1, 8'h3C, 1);
    tbl[14] = mk(0, 8'h11, 0, 0, 0, 0,  1, 1, 1, 0,  1, 8'h3C, 1);
    tbl[15] = mk(1, 8'h00, 0, 1, 0, 0,  0, 1, 2, 0,  1, 8'h3C, 1);
    tbl[16] = mk(1, 8'h00, 0, 1, 0, 0,  0, 1, 1, 0,  1, 8'h11, 0);
    tbl[17] = mk(1, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0,  0, 8'h00, 0);
    for (int i = 0; i < 18; i++) begin
      rx_empty = tbl[i].empty; rx_data = tbl[i].data; rx_frame_error = tbl[i].fe;
      m_ready = tbl[i].rdy; rx_overrun = tbl[i].ovr_in; err_clr = tbl[i].clr;
      sample();
      chk($sformatf("tbl%0d_unload", i), rx_unload, tbl[i].e_unl);
      chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_overrun", i), overrun, tbl[i].e_ovr);
      if (tbl[i].chk_d) begin
        chk($sformatf("tbl%0d_data", i), m_data, tbl[i].e_data);
        chk($sformatf("tbl%0d_fe", i), m_frame_error, tbl[i].e_fe);
      end
      advance();
    end
    rx_empty = 1'b1; rx_data = '0; rx_frame_error = 1'b0;
    m_ready = 1'b0; rx_overrun = 1'b0; err_clr = 1'b0;
    tick();

    // Fill to full, drop the 17th byte, drain in order
    for (int b = 0; b <= 16; b++) begin
      offer(8'(b), 1'b0, 1'b0);
      if (b == 15) chk("fill_full", full, 1);
    end
    chk("fill_overflow", overflow, 1);
    chk("fill_count", count, DEPTH);
    popped.delete();
    drain();
    chk("drain_len", popped.size(), DEPTH);
    for (int k = 0; k < DEPTH && k < popped.size(); k++) chk("drain_order", popped[k], k);

    // Wrap-around with a pop whenever the head is valid
    popped.delete();
    max_cnt = 0;
    m_ready = 1'b1;
    for (int b = 0; b < 40; b++) offer(8'(8'h80 + b), 1'b0, 1'b0);
    tick();
    m_ready = 1'b0;
    chk("wrap_len", popped.size(), 40);
    for (int k = 0; k < 40 && k < popped.size(); k++) chk("wrap_order", popped[k], 8'h80 + k);
    chk("wrap_max_cnt_le2", max_cnt <= 2, 1);

    // Simultaneous push and pop at full
    for (int b = 0; b < DEPTH; b++) offer(8'(8'h40 + b), 1'b0, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("sim_pre_overflow", overflow, 0);
    offer(8'h99, 1'b0, 1'b1);
    chk("sim_count", count, DEPTH);
    chk("sim_full", full, 1);
    chk("sim_overflow", overflow, 0);

    // Flush keeps sticky overflow
    offer(8'hEE, 1'b0, 1'b0);
    chk("pre_flush_overflow", overflow, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", m_valid, 0);
    chk("flush_overflow", overflow, 1);
    for (int b = 0; b < 5; b++) offer(8'(8'hC0 + b), 1'b1, 1'b0);
    chk("five_count", count, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush5_count", count, 0);
    chk("flush5_valid", m_valid, 0);
    chk("flush5_overflow", overflow, 1);

    // Asynchronous reset during the unload cycle
    offer(8'h21, 1'b0, 1'b0);
    rx_empty = 1'b0; rx_data = 8'h5A; rx_frame_error = 1'b0;
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (exp_unl) found = 1;
      else tick();
    end
    chk("rst_reach_unload", found, 1);
    #2;
    chk("rst_unload_before", rx_unload, 1);
    Resetn = 1'b0;
    #1;
    chk("rst_unload_async", rx_unload, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_overflow", overflow, 0);
    model_reset();
    @(posedge Clk);
    #1;
    Resetn = 1'b1;
    offer(8'h5A, 1'b0, 1'b0);
    chk("rst_redrain_count", count, 1);
    chk("rst_redrain_data", m_data, 8'h5A);
    drain();

    // Randomized traffic with late Empty updates, flushes and sticky events
    ctl_has = 0;
    late    = 0;
    bias    = 50;
    for (int i = 0; i < 2500; i++) begin
      if (i % 500 == 0) bias = (i / 500) % 2 == 0 ? 10 : 85;
      if (saw_unl) begin
        late = ($urandom_range(0, 3) == 0);
        if (!late) begin
          rx_empty = 1'b1;
          ctl_has  = 0;
        end
      end else if (late) begin
        late     = 0;
        rx_empty = 1'b1;
        ctl_has  = 0;
      end else if (!ctl_has && $urandom_range(0, 2) != 0) begin
        ctl_has        = 1;
        rx_empty       = 1'b0;
        rx_data        = 8'($urandom);
        rx_frame_error = 1'($urandom_range(0, 1));
      end
      m_ready    = ($urandom_range(0, 99) < bias);
      flush      = ($urandom_range(0, 199) == 0);
      err_clr    = ($urandom_range(0, 49) == 0);
      rx_overrun = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
